// File: rtl/pdl_ctl.sv
//-----------------------------------------------------------------------------
// pdl_ctl
//
// Purpose:
//   Sequencer and arbiter for the PDL buffer RAM. Owns the PDL pointer (PP)
//   and the PDL index (PI). Turns CPU micro-ops (push, pop, indexed read and
//   write, pointer load) into registered RAM strobes. It shares the RAM with a
//   debug spy port: the CPU has priority, but a spy request that has been
//   refused STARVE_LIMIT cycles in a row is forced through.
//
//   The RAM is synchronous with a 1-cycle read. An access accepted at edge E0
//   drives pdla/prp/pwp/pdl_wdata during E0..E1. The RAM acts at E1, and the
//   read data (pdlo, outside this block) is valid during E1..E2 together with
//   cpu_rd_valid or spy_rd_valid.
//
// Optional feature (macro PDL_BOUNDS_EN):
//   When defined, a PUSH at PP == all-ones sets the sticky pdl_ovf flag, and a
//   POP at PP == 0 sets the sticky pdl_unf flag. Both flags clear on reset or
//   on a LOAD. The access and the pointer wrap still happen. When the macro
//   is undefined, both flags are tied to 0.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset; clears all state
//   cpu_valid     in   CPU request present
//   cpu_op        in   3-bit op: 0 NOP, 1 PUSH, 2 POP, 3 RD_PP, 4 WR_PP,
//                      5 RD_PI, 6 WR_PI, 7 LOAD
//   cpu_wdata     in   write data; for LOAD, [9:0] goes to PP and [25:16] to PI
//   cpu_ready     out  CPU request accepted when cpu_valid & cpu_ready
//   cpu_rd_valid  out  RAM output holds the CPU read result this cycle
//   spy_req       in   spy access request, held until granted
//   spy_we        in   spy write (1) or read (0)
//   spy_addr      in   spy RAM address
//   spy_wdata     in   spy write data
//   spy_gnt       out  spy request accepted this cycle
//   spy_rd_valid  out  RAM output holds the spy read result this cycle
//   pdla          out  RAM address (registered)
//   prp           out  RAM read strobe (registered)
//   pwp           out  RAM write strobe (registered)
//   pdl_wdata     out  RAM write data (registered)
//   pp            out  current PDL pointer
//   pi            out  current PDL index
//   pdl_ovf       out  sticky push-wrap flag
//   pdl_unf       out  sticky pop-wrap flag
//-----------------------------------------------------------------------------
module pdl_ctl #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_valid,
    input  logic [2:0]            cpu_op,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_rd_valid,
    input  logic                  spy_req,
    input  logic                  spy_we,
    input  logic [ADDR_WIDTH-1:0] spy_addr,
    input  logic [DATA_WIDTH-1:0] spy_wdata,
    output logic                  spy_gnt,
    output logic                  spy_rd_valid,
    output logic [ADDR_WIDTH-1:0] pdla,
    output logic                  prp,
    output logic                  pwp,
    output logic [DATA_WIDTH-1:0] pdl_wdata,
    output logic [ADDR_WIDTH-1:0] pp,
    output logic [ADDR_WIDTH-1:0] pi,
    output logic                  pdl_ovf,
    output logic                  pdl_unf
);

    // The LOAD op takes PI from this bit position of cpu_wdata.
    localparam int PI_LSB = 16;

    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_RD_PP = 3'd3,
        OP_WR_PP = 3'd4,
        OP_RD_PI = 3'd5,
        OP_WR_PI = 3'd6,
        OP_LOAD  = 3'd7
    } cpu_op_e;

    // Registers
    logic [ADDR_WIDTH-1:0] r_pp;
    logic [ADDR_WIDTH-1:0] r_pi;
    logic [STARVE_W-1:0]   r_starve;
    logic [ADDR_WIDTH-1:0] r_pdla;
    logic                  r_prp;
    logic                  r_pwp;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_issue_spy;   // the access now on the strobes belongs to the spy
    logic                  r_cpu_rd_valid;
    logic                  r_spy_rd_valid;

    // Combinational
    cpu_op_e               w_op;
    logic                  w_cpu_req;
    logic                  w_starved;
    logic                  w_spy_gnt;
    logic                  w_cpu_go;
    logic [ADDR_WIDTH-1:0] w_pp_inc;
    logic [ADDR_WIDTH-1:0] w_pp_dec;
    logic [ADDR_WIDTH-1:0] w_pp_next;
    logic [ADDR_WIDTH-1:0] w_pi_next;
    logic [STARVE_W-1:0]   w_starve_next;
    logic [ADDR_WIDTH-1:0] w_pdla_next;
    logic                  w_prp_next;
    logic                  w_pwp_next;
    logic [DATA_WIDTH-1:0] w_wdata_next;
    logic                  w_issue_spy_next;

    assign w_op     = cpu_op_e'(cpu_op);
    assign w_pp_inc = r_pp + ADDR_WIDTH'(1);
    assign w_pp_dec = r_pp - ADDR_WIDTH'(1);

    //-------------------------------------------------------------------------
    // Arbitration. A NOP with cpu_valid set is not a request, so it lets
    // the spy through. Once the spy has been refused STARVE_LIMIT cycles in
    // a row, the spy wins and the CPU is held off.
    //-------------------------------------------------------------------------
    always_comb begin
        w_cpu_req = cpu_valid & (w_op != OP_NOP);
        w_starved = (r_starve == STARVE_MAX);
        w_spy_gnt = spy_req & (~w_cpu_req | w_starved);
        w_cpu_go  = w_cpu_req & ~w_spy_gnt;
        cpu_ready = ~(spy_req & w_starved);
        spy_gnt   = w_spy_gnt;
    end

    // The counter never passes STARVE_MAX, because at that value the spy is
    // granted and the count returns to zero.
    always_comb begin
        w_starve_next = '0;
        if (spy_req && !w_spy_gnt) begin
            w_starve_next = r_starve + STARVE_W'(1);
        end
    end

    //-------------------------------------------------------------------------
    // Issue stage: pick the next RAM access and the pointer updates.
    // Idle cycles and LOADs hold address and data and drop both strobes.
    //-------------------------------------------------------------------------
    always_comb begin
        w_pp_next        = r_pp;
        w_pi_next        = r_pi;
        w_pdla_next      = r_pdla;
        w_wdata_next     = r_wdata;
        w_prp_next       = 1'b0;
        w_pwp_next       = 1'b0;
        w_issue_spy_next = 1'b0;

        if (w_spy_gnt) begin
            w_issue_spy_next = 1'b1;
            w_pdla_next      = spy_addr;
            if (spy_we) begin
                w_pwp_next   = 1'b1;
                w_wdata_next = spy_wdata;
            end else begin
                w_prp_next   = 1'b1;
            end
        end else if (w_cpu_go) begin
            unique case (w_op)
                OP_PUSH: begin
                    w_pdla_next  = w_pp_inc;
                    w_wdata_next = cpu_wdata;
                    w_pwp_next   = 1'b1;
                    w_pp_next    = w_pp_inc;
                end
                OP_POP: begin
                    w_pdla_next  = r_pp;
                    w_prp_next   = 1'b1;
                    w_pp_next    = w_pp_dec;
                end
                OP_RD_PP: begin
                    w_pdla_next  = r_pp;
                    w_prp_next   = 1'b1;
                end
                OP_WR_PP: begin
                    w_pdla_next  = r_pp;
                    w_wdata_next = cpu_wdata;
                    w_pwp_next   = 1'b1;
                end
                OP_RD_PI: begin
                    w_pdla_next  = r_pi;
                    w_prp_next   = 1'b1;
                end
                OP_WR_PI: begin
                    w_pdla_next  = r_pi;
                    w_wdata_next = cpu_wdata;
                    w_pwp_next   = 1'b1;
                end
                OP_LOAD: begin
                    w_pp_next    = cpu_wdata[ADDR_WIDTH-1:0];
                    w_pi_next    = cpu_wdata[PI_LSB +: ADDR_WIDTH];
                end
                default: begin
                    // OP_NOP is not a request, so the arbiter never lets it get here.
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // State and output registers. The read-valid flags follow the read strobe
    // by one cycle. The RAM is read at the edge that launches the valid flag,
    // so an asynchronous reset during the strobe cycle also drops the read.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pp           <= '0;
            r_pi           <= '0;
            r_starve       <= '0;
            r_pdla         <= '0;
            r_prp          <= 1'b0;
            r_pwp          <= 1'b0;
            r_wdata        <= '0;
            r_issue_spy    <= 1'b0;
            r_cpu_rd_valid <= 1'b0;
            r_spy_rd_valid <= 1'b0;
        end else begin
            r_pp           <= w_pp_next;
            r_pi           <= w_pi_next;
            r_starve       <= w_starve_next;
            r_pdla         <= w_pdla_next;
            r_prp          <= w_prp_next;
            r_pwp          <= w_pwp_next;
            r_wdata        <= w_wdata_next;
            r_issue_spy    <= w_issue_spy_next;
            r_cpu_rd_valid <= r_prp & ~r_issue_spy;
            r_spy_rd_valid <= r_prp & r_issue_spy;
        end
    end

    assign pdla         = r_pdla;
    assign prp          = r_prp;
    assign pwp          = r_pwp;
    assign pdl_wdata    = r_wdata;
    assign pp           = r_pp;
    assign pi           = r_pi;
    assign cpu_rd_valid = r_cpu_rd_valid;
    assign spy_rd_valid = r_spy_rd_valid;

`ifdef PDL_BOUNDS_EN
    //-------------------------------------------------------------------------
    // Sticky wrap flags. They are set from the pointer value before the
    // update, so the flag rises in the same cycle as the wrapped PP.
    //-------------------------------------------------------------------------
    logic r_ovf;
    logic r_unf;
    logic w_ovf_next;
    logic w_unf_next;

    always_comb begin
        w_ovf_next = r_ovf;
        w_unf_next = r_unf;
        if (w_cpu_go) begin
            if (w_op == OP_PUSH && r_pp == '1) begin
                w_ovf_next = 1'b1;
            end
            if (w_op == OP_POP && r_pp == '0) begin
                w_unf_next = 1'b1;
            end
            if (w_op == OP_LOAD) begin
                w_ovf_next = 1'b0;
                w_unf_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_next;
            r_unf <= w_unf_next;
        end
    end

    assign pdl_ovf = r_ovf;
    assign pdl_unf = r_unf;
`else
    assign pdl_ovf = 1'b0;
    assign pdl_unf = 1'b0;
`endif

endmodule
